// File: rtl/ysyx_24100029_axi_arbiter_pkg.sv
// Shared constants for the IFU/LSU AXI4 arbiter: grant-state encoding and the
// AXI field values the arbiter and its users agree on.
package ysyx_24100029_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFU_RD = 2'd1,
    ARB_LSU_RD = 2'd2,
    ARB_LSU_WR = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [2:0] SIZE_4B     = 3'b010;

endpackage

// File: rtl/ysyx_24100029_arb_watchdog.sv
// Counts cycles of an open grant and flags the cycle on which it has been held
// for TIMEOUT cycles; TIMEOUT of 0 disables the watchdog.
module ysyx_24100029_arb_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic busy,
  output logic expire
);

  localparam logic [15:0] LIMIT = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  logic [15:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || !busy) cnt <= '0;
    else                cnt <= cnt + 16'd1;
  end

  assign expire = (TIMEOUT != 0) && busy && (cnt == LIMIT);

endmodule

// File: rtl/ysyx_24100029_axi_arbiter.sv
// Two-master/one-slave AXI4 arbiter: one whole transaction at a time, the state
// register is the grant, and channel routing is decoded combinationally from it.
import ysyx_24100029_axi_arbiter_pkg::*;

module ysyx_24100029_axi_arbiter #(
  parameter int TIMEOUT = 1024,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [3:0]        m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic [3:0]        m0_rid,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [3:0]        m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic [3:0]        m1_rid,
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [3:0]        m1_awid,
  input  logic [7:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic              m1_wlast,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  output logic [1:0]        m1_bresp,
  output logic [3:0]        m1_bid,
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [3:0]        s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [3:0]        s_rid,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [3:0]        s_awid,
  output logic [7:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [DATA_W-1:0] s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic              s_wlast,
  input  logic              s_bvalid,
  output logic              s_bready,
  input  logic [1:0]        s_bresp,
  input  logic [3:0]        s_bid,
  output logic              busy,
  output logic [1:0]        grant_id,
  output logic              err_timeout
);

  arb_state_e state, state_nx;
  logic       expire;

  always_ff @(posedge clock) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nx;
  end

  assign busy        = (state != ARB_IDLE);
  assign grant_id    = state;
  assign err_timeout = expire;

  ysyx_24100029_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .busy   (busy),
    .expire (expire)
  );

  // Payloads are steered unconditionally; only the handshakes carry the grant.
  assign s_araddr  = (state == ARB_LSU_RD) ? m1_araddr  : m0_araddr;
  assign s_arid    = (state == ARB_LSU_RD) ? m1_arid    : m0_arid;
  assign s_arlen   = (state == ARB_LSU_RD) ? m1_arlen   : m0_arlen;
  assign s_arsize  = (state == ARB_LSU_RD) ? m1_arsize  : m0_arsize;
  assign s_arburst = (state == ARB_LSU_RD) ? m1_arburst : m0_arburst;
  assign s_awaddr  = m1_awaddr;
  assign s_awid    = m1_awid;
  assign s_awlen   = m1_awlen;
  assign s_awsize  = m1_awsize;
  assign s_awburst = m1_awburst;
  assign s_wdata   = m1_wdata;
  assign s_wstrb   = m1_wstrb;
  assign s_wlast   = m1_wlast;
  assign m0_rdata  = s_rdata;
  assign m0_rid    = s_rid;
  assign m1_rdata  = s_rdata;
  assign m1_rid    = s_rid;
  assign m1_bid    = s_bid;

  always_comb begin
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m0_rresp   = s_rresp;
    m0_rlast   = s_rlast;
    m1_rresp   = s_rresp;
    m1_rlast   = s_rlast;
    m1_bresp   = s_bresp;
    if (expire) begin
      // Slave is cut off; the granted master gets a synthetic final SLVERR beat.
      case (state)
        ARB_IFU_RD: begin m0_rvalid = 1'b1; m0_rresp = RESP_SLVERR; m0_rlast = 1'b1; end
        ARB_LSU_RD: begin m1_rvalid = 1'b1; m1_rresp = RESP_SLVERR; m1_rlast = 1'b1; end
        ARB_LSU_WR: begin m1_bvalid = 1'b1; m1_bresp = RESP_SLVERR; end
        default: ;
      endcase
    end else begin
      case (state)
        ARB_IFU_RD: begin
          s_arvalid  = m0_arvalid;
          m0_arready = s_arready;
          m0_rvalid  = s_rvalid;
          s_rready   = m0_rready;
        end
        ARB_LSU_RD: begin
          s_arvalid  = m1_arvalid;
          m1_arready = s_arready;
          m1_rvalid  = s_rvalid;
          s_rready   = m1_rready;
        end
        ARB_LSU_WR: begin
          s_awvalid  = m1_awvalid;
          m1_awready = s_awready;
          s_wvalid   = m1_wvalid;
          m1_wready  = s_wready;
          m1_bvalid  = s_bvalid;
          s_bready   = m1_bready;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ARB_IDLE: begin
        if (m1_awvalid || m1_wvalid) state_nx = ARB_LSU_WR;
        else if (m1_arvalid)         state_nx = ARB_LSU_RD;
        else if (m0_arvalid)         state_nx = ARB_IFU_RD;
      end
      ARB_IFU_RD: if (expire || (s_rvalid && m0_rready && s_rlast)) state_nx = ARB_IDLE;
      ARB_LSU_RD: if (expire || (s_rvalid && m1_rready && s_rlast)) state_nx = ARB_IDLE;
      ARB_LSU_WR: if (expire || (s_bvalid && m1_bready))            state_nx = ARB_IDLE;
      default:    state_nx = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24100029_axi_arbiter.sv
// Self-checking bench for the IFU/LSU AXI arbiter: directed scenarios followed by
// random traffic, every cycle compared against a transaction-level owner model.
import ysyx_24100029_axi_arbiter_pkg::*;

module tb_ysyx_24100029_axi_arbiter;

  localparam int TMO = 16;

  logic clock = 1'b0;
  logic reset;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [3:0]  m0_arid, m0_rid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst, m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [3:0]  m1_arid, m1_rid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst, m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_awid, m1_wstrb, m1_bid;
  logic [7:0]  m1_awlen;
  logic [2:0]  m1_awsize;
  logic [1:0]  m1_awburst, m1_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_awid, s_wstrb, s_bid;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst, s_bresp;
  logic        busy, err_timeout;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;
  // Model: who owns the slave port (0 none, 1 IFU read, 2 LSU read, 3 LSU write)
  // and how many cycles that ownership has already lasted.
  int owner = 0;
  int age   = 0;

  always #5 clock = ~clock;

  ysyx_24100029_axi_arbiter #(.TIMEOUT(TMO), .ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
    .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .m1_bid(m1_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic quiet();
    reset = 1'b0;
    {m0_arvalid, m0_rready, m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready} = '0;
    {s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid} = '0;
    m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = SIZE_4B; m0_arburst = BURST_FIXED;
    m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = SIZE_4B; m1_arburst = BURST_FIXED;
    m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = SIZE_4B; m1_awburst = BURST_FIXED;
    m1_wdata = '0; m1_wstrb = '0; m1_wlast = 1'b0;
    s_rdata = '0; s_rresp = RESP_OKAY; s_rid = '0; s_bresp = RESP_OKAY; s_bid = '0;
  endtask

  // Compare every DUT output against what the current owner implies.
  task automatic check_outputs();
    bit ex, rd0, rd1, wr, e_s_ar, e_s_aw, e_s_w, e_m0_r, e_m1_r, e_m1_b;
    ex  = (owner != 0) && (age + 1 == TMO);
    rd0 = (owner == 1) && !ex;
    rd1 = (owner == 2) && !ex;
    wr  = (owner == 3) && !ex;
    e_s_ar = rd0 ? m0_arvalid : (rd1 ? m1_arvalid : 1'b0);
    e_s_aw = wr & m1_awvalid;
    e_s_w  = wr & m1_wvalid;
    e_m0_r = (rd0 & s_rvalid) | ((owner == 1) & ex);
    e_m1_r = (rd1 & s_rvalid) | ((owner == 2) & ex);
    e_m1_b = (wr & s_bvalid) | ((owner == 3) & ex);
    chk("busy", 64'(busy), 64'(owner != 0));
    chk("grant_id", 64'(grant_id), 64'(owner));
    chk("err_timeout", 64'(err_timeout), 64'(ex));
    chk("s_arvalid", 64'(s_arvalid), 64'(e_s_ar));
    chk("s_rready", 64'(s_rready), 64'(rd0 ? m0_rready : (rd1 ? m1_rready : 1'b0)));
    chk("m0_arready", 64'(m0_arready), 64'(rd0 & s_arready));
    chk("m1_arready", 64'(m1_arready), 64'(rd1 & s_arready));
    chk("m0_rvalid", 64'(m0_rvalid), 64'(e_m0_r));
    chk("m1_rvalid", 64'(m1_rvalid), 64'(e_m1_r));
    chk("s_awvalid", 64'(s_awvalid), 64'(e_s_aw));
    chk("s_wvalid", 64'(s_wvalid), 64'(e_s_w));
    chk("s_bready", 64'(s_bready), 64'(wr & m1_bready));
    chk("m1_awready", 64'(m1_awready), 64'(wr & s_awready));
    chk("m1_wready", 64'(m1_wready), 64'(wr & s_wready));
    chk("m1_bvalid", 64'(m1_bvalid), 64'(e_m1_b));
    if (e_s_ar) begin
      chk("s_araddr", 64'(s_araddr), 64'(owner == 1 ? m0_araddr : m1_araddr));
      chk("s_arid", 64'(s_arid), 64'(owner == 1 ? m0_arid : m1_arid));
    end
    if (e_s_aw) chk("s_awaddr", 64'(s_awaddr), 64'(m1_awaddr));
    if (e_s_w) chk("s_wdata", 64'({s_wstrb, s_wdata}), 64'({m1_wstrb, m1_wdata}));
    if (e_m0_r && ex) chk("m0_rresp_err", 64'({m0_rresp, m0_rlast}), 64'({RESP_SLVERR, 1'b1}));
    if (e_m0_r && !ex) chk("m0_rbeat", 64'({m0_rid, m0_rresp, m0_rdata}), 64'({s_rid, s_rresp, s_rdata}));
    if (e_m1_r && ex) chk("m1_rresp_err", 64'({m1_rresp, m1_rlast}), 64'({RESP_SLVERR, 1'b1}));
    if (e_m1_r && !ex) chk("m1_rbeat", 64'({m1_rid, m1_rresp, m1_rdata}), 64'({s_rid, s_rresp, s_rdata}));
    if (e_m1_b) chk("m1_bresp", 64'(m1_bresp), 64'(ex ? RESP_SLVERR : s_bresp));
    if (e_m1_b && !ex) chk("m1_bid", 64'(m1_bid), 64'(s_bid));
  endtask

  // One clock: inputs already driven (after a negedge), check, then advance the model.
  task automatic cycle();
    int nx;
    bit ex;
    #1;
    check_outputs();
    ex = (owner != 0) && (age + 1 == TMO);
    if (reset) nx = 0;
    else if (owner == 0) nx = (m1_awvalid || m1_wvalid) ? 3 : (m1_arvalid ? 2 : (m0_arvalid ? 1 : 0));
    else if (ex) nx = 0;
    else if (owner == 1) nx = (s_rvalid && m0_rready && s_rlast) ? 0 : 1;
    else if (owner == 2) nx = (s_rvalid && m1_rready && s_rlast) ? 0 : 2;
    else nx = (s_bvalid && m1_bready) ? 0 : 3;
    @(posedge clock);
    age   = (owner != 0 && nx != 0) ? age + 1 : 0;
    owner = nx;
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    quiet();
    reset = 1'b1;
    @(posedge clock);
    owner = 0; age = 0;
    @(negedge clock);
    cycle();                     // reset held: idle outputs
    reset = 1'b0;
    run(2);

    // IFU read alone
    m0_arvalid = 1'b1; m0_araddr = 32'h0f00_0000;
    cycle();
    s_arready = 1'b1;
    #1 chk("ifu_grant", 64'({busy, grant_id, s_arvalid}), 64'({1'b1, 2'd1, 1'b1}));
    cycle();
    m0_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h0000_0413; s_rlast = 1'b1; m0_rready = 1'b1;
    #1 chk("ifu_rdata", 64'(m0_rdata), 64'h413);
    cycle();
    quiet();
    #1 chk("ifu_release", 64'(grant_id), 64'd0);
    run(1);

    // Simultaneous IFU and LSU read requests: LSU first
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000; m1_arvalid = 1'b1; m1_araddr = 32'h8000_0000;
    m1_arid = 4'h5; m0_rready = 1'b1; m1_rready = 1'b1;
    cycle();
    s_arready = 1'b1;
    run(1);
    m1_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'h1234_5678; s_rid = 4'h5;
    run(1);
    s_rvalid = 1'b0; s_rlast = 1'b0;
    run(2);
    s_arready = 1'b1;
    run(1);
    m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rresp = RESP_SLVERR;
    run(1);
    quiet();
    run(1);

    // LSU write, W two cycles before AW, IFU waiting throughout
    m1_wvalid = 1'b1; m1_wdata = 32'hdead_beef; m1_wstrb = 4'b1111; m1_wlast = 1'b1;
    m0_arvalid = 1'b1; s_wready = 1'b1;
    run(2);
    m1_wvalid = 1'b0; s_wready = 1'b0;
    m1_awvalid = 1'b1; m1_awaddr = 32'h8000_0100;
    run(1);
    m1_awvalid = 1'b0; s_awready = 1'b0;
    run(1);
    s_bvalid = 1'b1; s_bid = 4'h3; m1_bready = 1'b1;
    run(1);
    s_bvalid = 1'b0; m1_bready = 1'b0;
    run(3);
    quiet();
    run(2);

    // Slave stalls 5 cycles, then master holds rready low for 3
    m0_arvalid = 1'b1; m0_araddr = 32'h0000_1000; s_arready = 1'b1;
    run(2);
    quiet();
    run(5);
    s_rvalid = 1'b1; s_rlast = 1'b1;
    run(3);
    m0_rready = 1'b1;
    run(1);
    quiet();
    run(1);

    // Slave never responds: watchdog fires on busy cycle TMO
    m0_arvalid = 1'b1;
    run(1);
    m0_arvalid = 1'b0;
    run(TMO - 1);
    #1 chk("wd_fire", 64'({err_timeout, m0_rvalid, m0_rresp}), 64'({1'b1, 1'b1, RESP_SLVERR}));
    run(1);
    #1 chk("wd_idle", 64'({busy, err_timeout, m0_rvalid}), 64'd0);
    run(1);

    // Reset in the middle of an LSU write after AW accepted, then a fresh IFU read
    m1_awvalid = 1'b1; s_awready = 1'b1;
    run(2);
    quiet();
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    #1 chk("post_reset", 64'({busy, grant_id, err_timeout, s_awvalid, m1_awready}), 64'd0);
    m0_arvalid = 1'b1; s_arready = 1'b1;
    run(2);
    quiet();
    s_rvalid = 1'b1; s_rlast = 1'b1; m0_rready = 1'b1;
    run(2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      m0_arvalid = ($urandom_range(0, 3) == 0);
      m1_arvalid = ($urandom_range(0, 5) == 0);
      m1_awvalid = ($urandom_range(0, 7) == 0);
      m1_wvalid  = ($urandom_range(0, 7) == 0);
      m0_rready  = 1'($urandom_range(0, 1));
      m1_rready  = 1'($urandom_range(0, 1));
      m1_bready  = 1'($urandom_range(0, 1));
      s_arready  = 1'($urandom_range(0, 1));
      s_awready  = 1'($urandom_range(0, 1));
      s_wready   = 1'($urandom_range(0, 1));
      s_rvalid   = 1'($urandom_range(0, 1));
      s_rlast    = 1'($urandom_range(0, 1));
      s_bvalid   = ($urandom_range(0, 2) == 0);
      m0_araddr  = $urandom; m1_araddr = $urandom; m1_awaddr = $urandom;
      m0_arid    = 4'($urandom); m1_arid = 4'($urandom);
      m1_wdata   = $urandom; m1_wstrb = 4'($urandom);
      s_rdata    = $urandom; s_rresp = 2'($urandom); s_rid = 4'($urandom);
      s_bresp    = 2'($urandom); s_bid = 4'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
